// File: rtl/fifo_memory_bram.sv
// fifo_memory_bram: true dual-port 256x72 block RAM for the packet FIFO.
// Both ports read every cycle into a registered output (one-cycle latency).
// Write mode is read-first on each port and across ports. When both ports
// write the same address in one cycle, port A wins. Reset clears only the
// output registers; array contents survive reset.
module fifo_memory_bram #(
  parameter int WIDTH     = 72,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addra,
  input  logic [WIDTH-1:0]     dina,
  input  logic                 wea,
  output logic [WIDTH-1:0]     douta,
  input  logic [ADDR_BITS-1:0] addrb,
  input  logic [WIDTH-1:0]     dinb,
  input  logic                 web,
  output logic [WIDTH-1:0]     doutb
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Storage array; the declaration initialiser gives the all-zero power-up image.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [WIDTH-1:0] douta_q;
  logic [WIDTH-1:0] doutb_q;
  logic             wr_a_en;
  logic             wr_b_en;
  logic             same_addr;

  // Effective write enables: writes are blocked while reset is high.
  // Port B also yields to port A when both target the same word.
  always_comb begin
    same_addr = (addra == addrb);
    wr_a_en   = wea & ~reset;
    wr_b_en   = web & ~reset & ~(wea & same_addr);
  end

  // Array writes. Port B is issued first and port A last, so A would win even
  // without the explicit drop in wr_b_en.
  always_ff @(posedge clk) begin
    if (wr_b_en) begin
      mem[addrb] <= dinb;
    end
    if (wr_a_en) begin
      mem[addra] <= dina;
    end
  end

  // Registered reads. The non-blocking write above leaves the old word visible
  // here, which gives read-first behaviour on both ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= mem[addra];
      doutb_q <= mem[addrb];
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;

endmodule

// File: tb/tb_fifo_memory_bram.sv
// Directed self-checking bench for fifo_memory_bram.
module tb_fifo_memory_bram;

  localparam int WIDTH     = 72;
  localparam int ADDR_BITS = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ADDR_BITS-1:0] addra, addrb;
  logic [WIDTH-1:0]     dina, dinb;
  logic                 wea, web;
  logic [WIDTH-1:0]     douta, doutb;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [WIDTH-1:0] V_DEAD = 72'h00_DEAD_BEEF_0123_4567;

  fifo_memory_bram #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .addra (addra),
    .dina  (dina),
    .wea   (wea),
    .douta (douta),
    .addrb (addrb),
    .dinb  (dinb),
    .web   (web),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;

    reset = 1'b1;
    addra = '0; addrb = '0; dina = '0; dinb = '0; wea = 1'b0; web = 1'b0;

    // Reset for two cycles: both outputs zero.
    tick(); tick();
    chk("reset_douta", douta, '0);
    chk("reset_doutb", doutb, '0);
    $display("step reset: douta=%h doutb=%h", douta, doutb);

    // Read of an untouched address after reset returns zero.
    reset = 1'b0; addrb = 8'h10;
    tick();
    chk("init_read_10", doutb, '0);
    $display("step read 0x10: doutb=%h", doutb);

    // Write via A, read via B next cycle.
    addra = 8'h05; dina = V_DEAD; wea = 1'b1;
    tick();
    wea = 1'b0; addrb = 8'h05;
    tick();
    chk("wr_rd_05", doutb, V_DEAD);
    $display("step write/read 0x05: doutb=%h", doutb);

    // Read-first collision at 0x20.
    addra = 8'h20; dina = 72'hAA; wea = 1'b1;
    tick();
    dina = 72'hBB; addrb = 8'h20;
    tick();
    chk("rf_douta_20", douta, 72'hAA);
    chk("rf_doutb_20", doutb, 72'hAA);
    $display("step collision 0x20: douta=%h doutb=%h", douta, doutb);
    wea = 1'b0;
    tick();
    chk("rf_after_a_20", douta, 72'hBB);
    chk("rf_after_b_20", doutb, 72'hBB);
    $display("step reread 0x20: douta=%h doutb=%h", douta, doutb);

    // Dual write to 0x7F: A wins.
    addra = 8'h7F; addrb = 8'h7F; dina = 72'h1; dinb = 72'h2; wea = 1'b1; web = 1'b1;
    tick();
    chk("dw_old_b_7f", doutb, '0);
    wea = 1'b0; web = 1'b0;
    tick();
    chk("dw_win_a_7f", douta, 72'h1);
    chk("dw_win_b_7f", doutb, 72'h1);
    $display("step dual write 0x7F: douta=%h doutb=%h", douta, doutb);

    // Full sweep: A writes mem[i]=i while B reads i-2.
    for (int i = 0; i < 256; i++) begin
      addra = 8'(i); dina = WIDTH'(i); wea = 1'b1; addrb = 8'(i - 2);
      tick();
      exp_b = (i < 2) ? '0 : WIDTH'(i - 2);
      if (i == 5)        exp_a = V_DEAD;
      else if (i == 32)  exp_a = 72'hBB;
      else if (i == 127) exp_a = 72'h1;
      else               exp_a = '0;
      chk($sformatf("sweep_b_%0d", i), doutb, exp_b);
      chk($sformatf("sweep_a_%0d", i), douta, exp_a);
      $display("sweep i=%0d douta=%h doutb=%h", i, douta, doutb);
    end
    wea = 1'b0; addrb = 8'd254;
    tick();
    chk("sweep_tail_254", doutb, 72'd254);
    addrb = 8'd255;
    tick();
    chk("sweep_tail_255", doutb, 72'd255);
    $display("step sweep tail: doutb=%h", doutb);

    // Port B write with port A reading the same word: A sees the old value.
    addrb = 8'h40; dinb = 72'h77; web = 1'b1; addra = 8'h40;
    tick();
    chk("xrf_douta_40", douta, 72'h40);
    chk("xrf_doutb_40", doutb, 72'h40);
    web = 1'b0;
    tick();
    chk("xrf_new_a_40", douta, 72'h77);
    $display("step port B write 0x40: douta=%h doutb=%h", douta, doutb);

    // Reset mid-stream: outputs clear, contents and ignored write preserved.
    addra = 8'h30; dina = 72'h55; wea = 1'b1;
    tick();
    wea = 1'b0; addrb = 8'h30;
    tick();
    chk("ms_pre_b_30", doutb, 72'h55);
    reset = 1'b1; wea = 1'b1; dina = 72'h99;
    tick();
    chk("ms_rst_b", doutb, '0);
    chk("ms_rst_a", douta, '0);
    $display("step mid reset: douta=%h doutb=%h", douta, doutb);
    reset = 1'b0; wea = 1'b0;
    tick();
    chk("ms_post_b_30", doutb, 72'h55);
    chk("ms_post_a_30", douta, 72'h55);
    $display("step after reset: douta=%h doutb=%h", douta, doutb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
